// File: rtl/control_multiplicador_if.sv
// Handshake bundle between the multiply/convert controller and its two
// helper engines: the Booth multiplier and the binary-to-BCD converter.
interface control_multiplicador_if;
    // Multiplier side
    logic        mult_valid;
    logic [7:0]  mult_A;
    logic [7:0]  mult_B;
    logic        mult_done;
    logic [15:0] mult_resultado;

    // BCD converter side
    logic        bcd_start;
    logic [14:0] bcd_bin;
    logic        bcd_done;
    logic [19:0] bcd_codigo;

    // Controller view: issues starts and operands, receives completions.
    modport master (
        output mult_valid, mult_A, mult_B,
        input  mult_done, mult_resultado,
        output bcd_start, bcd_bin,
        input  bcd_done, bcd_codigo
    );

    // Engine view: receives starts and operands, returns completions.
    modport slave (
        input  mult_valid, mult_A, mult_B,
        output mult_done, mult_resultado,
        input  bcd_start, bcd_bin,
        output bcd_done, bcd_codigo
    );
endinterface

// File: rtl/control_multiplicador.sv
// Sequencer for a signed 8x8 multiply followed by a BCD conversion of the
// product magnitude. A start request is launched into the multiplier, the
// product is split into sign and magnitude, the magnitude is converted and
// the signed BCD code is published to the display. Each wait state is
// guarded by a cycle counter, and one start request arriving while busy is
// held in a single-entry buffer (latest request wins).
module control_multiplicador #(
    parameter int TIMEOUT_CICLOS = 1000
) (
    input  logic                           CLK100MHZ,
    input  logic                           reset,
    input  logic                           pb_pulso,
    input  logic [7:0]                     A_in,
    input  logic [7:0]                     B_in,
    control_multiplicador_if.master        bus,
    output logic [20:0]                    codigo_BCD,
    output logic                           ocupado,
    output logic                           hecho,
    output logic                           error_timeout
);

    typedef enum logic [2:0] {
        REPOSO,
        CARGA,
        ESPERA_MULT,
        CONVIERTE,
        ESPERA_BCD,
        PUBLICA
    } state_e;

    localparam int                CNT_W   = $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CICLOS - 1);

    state_e             state_q, state_d;

    logic [7:0]         op_a_q, op_a_d;
    logic [7:0]         op_b_q, op_b_d;
    logic               signo_q, signo_d;
    logic [15:0]        producto_q, producto_d;
    logic [20:0]        codigo_q, codigo_d;
    logic               error_q, error_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pend_valid_q, pend_valid_d;
    logic [7:0]         pend_a_q, pend_a_d;
    logic [7:0]         pend_b_q, pend_b_d;

    logic               en_espera;
    logic               arranque;

    // Wait-state flag and "a run starts now" flag shared by both comb blocks.
    always_comb begin
        en_espera = (state_q == ESPERA_MULT) || (state_q == ESPERA_BCD);
        arranque  = (state_q == REPOSO) && (pb_pulso || pend_valid_q);
    end

    // State register.
    always_ff @(posedge CLK100MHZ or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples the pre-edge value of its neighbours, independent of the
        // order the simulator evaluates the blocks in.
        if (!reset) begin
            state_q <= REPOSO;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a wait state gives up once the counter hits its limit.
    always_comb begin
        // NOTE: defaulting to the current state before the case keeps every
        // path assigned, so no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            REPOSO: begin
                if (arranque) state_d = CARGA;
            end
            CARGA: begin
                state_d = ESPERA_MULT;
            end
            ESPERA_MULT: begin
                if (bus.mult_done)         state_d = CONVIERTE;
                else if (cnt_q == CNT_MAX) state_d = REPOSO;
            end
            CONVIERTE: begin
                state_d = ESPERA_BCD;
            end
            ESPERA_BCD: begin
                if (bus.bcd_done)          state_d = PUBLICA;
                else if (cnt_q == CNT_MAX) state_d = REPOSO;
            end
            PUBLICA: begin
                state_d = REPOSO;
            end
            default: begin
                state_d = REPOSO;
            end
        endcase
    end

    // Datapath next values: operands, product, published code, pending
    // request buffer, timeout flag and wait-state counter.
    always_comb begin
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        signo_d      = signo_q;
        producto_d   = producto_q;
        codigo_d     = codigo_q;
        error_d      = error_q;
        pend_valid_d = pend_valid_q;
        pend_a_d     = pend_a_q;
        pend_b_d     = pend_b_q;
        cnt_d        = '0;

        if (arranque) begin
            // A fresh pulse is newer than anything sitting in the buffer.
            op_a_d       = pb_pulso ? A_in : pend_a_q;
            op_b_d       = pb_pulso ? B_in : pend_b_q;
            pend_valid_d = 1'b0;
            error_d      = 1'b0;
        end else if (pb_pulso) begin
            // Busy (or leaving a run this cycle): park the request.
            pend_valid_d = 1'b1;
            pend_a_d     = A_in;
            pend_b_d     = B_in;
        end

        if ((state_q == ESPERA_MULT) && bus.mult_done) begin
            signo_d    = bus.mult_resultado[15];
            producto_d = bus.mult_resultado;
        end

        if ((state_q == ESPERA_BCD) && bus.bcd_done) begin
            codigo_d = {signo_q, bus.bcd_codigo};
        end

        // Counter restarts on every wait-state entry and only runs while the
        // FSM stays put; falling back to REPOSO from a wait state is an abort.
        if (en_espera && (state_d == state_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (en_espera && (state_d == REPOSO)) begin
            error_d = 1'b1;
        end
    end

    // Datapath registers, all cleared by reset.
    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            op_a_q       <= '0;
            op_b_q       <= '0;
            signo_q      <= 1'b0;
            producto_q   <= '0;
            codigo_q     <= '0;
            error_q      <= 1'b0;
            cnt_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_a_q     <= '0;
            pend_b_q     <= '0;
        end else begin
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            signo_q      <= signo_d;
            producto_q   <= producto_d;
            codigo_q     <= codigo_d;
            error_q      <= error_d;
            cnt_q        <= cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_a_q     <= pend_a_d;
            pend_b_q     <= pend_b_d;
        end
    end

    // Outputs: one-cycle strobes decoded from state, the rest from registers.
    // Magnitude never exceeds 16384, so the low 15 bits are always exact.
    always_comb begin
        bus.mult_valid = (state_q == CARGA);
        bus.mult_A     = op_a_q;
        bus.mult_B     = op_b_q;
        bus.bcd_start  = (state_q == CONVIERTE);
        bus.bcd_bin    = 15'(signo_q ? (~producto_q + 16'd1) : producto_q);
        codigo_BCD     = codigo_q;
        ocupado        = (state_q != REPOSO);
        hecho          = (state_q == PUBLICA);
        error_timeout  = error_q;
    end

endmodule

// File: tb/tb_control_multiplicador.sv
// Directed bench for control_multiplicador. The bench plays the multiplier
// and the BCD converter; expected operands, magnitudes and published codes
// are queued when stimulus is issued and popped by responder/monitor
// processes whenever the DUT presents a start or a completion.
module tb_control_multiplicador;

    logic        CLK100MHZ = 1'b0;
    logic        reset     = 1'b0;
    logic        pb_pulso  = 1'b0;
    logic [7:0]  A_in      = '0;
    logic [7:0]  B_in      = '0;
    logic [20:0] codigo_BCD;
    logic        ocupado;
    logic        hecho;
    logic        error_timeout;

    always #5 CLK100MHZ = ~CLK100MHZ;

    control_multiplicador_if bus ();

    // Engine responses: automatic responders plus manual overrides.
    logic        resp_mult_done = 1'b0;
    logic [15:0] resp_mult_res  = '0;
    logic        man_mult_done  = 1'b0;
    logic [15:0] man_mult_res   = '0;
    logic        resp_bcd_done  = 1'b0;
    logic [19:0] resp_bcd_cod   = '0;
    logic        man_bcd_done   = 1'b0;

    assign bus.mult_done      = resp_mult_done | man_mult_done;
    assign bus.mult_resultado = man_mult_done ? man_mult_res : resp_mult_res;
    assign bus.bcd_done       = resp_bcd_done | man_bcd_done;
    assign bus.bcd_codigo     = resp_bcd_cod;

    control_multiplicador #(.TIMEOUT_CICLOS(1000)) dut (
        .CLK100MHZ     (CLK100MHZ),
        .reset         (reset),
        .pb_pulso      (pb_pulso),
        .A_in          (A_in),
        .B_in          (B_in),
        .bus           (bus),
        .codigo_BCD    (codigo_BCD),
        .ocupado       (ocupado),
        .hecho         (hecho),
        .error_timeout (error_timeout)
    );

    typedef struct packed {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
    } mult_exp_t;

    typedef struct packed {
        logic [14:0] mag;
        logic [19:0] code;
    } bcd_exp_t;

    mult_exp_t   mult_q[$];
    bcd_exp_t    bcd_q[$];
    logic [20:0] pub_q[$];

    bit mult_mute = 1'b0;
    int bcd_delay = 2;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Multiplier model: checks operands on mult_valid and answers later.
    initial begin : mult_responder
        mult_exp_t e;
        forever begin
            @(negedge CLK100MHZ);
            if (bus.mult_valid && !mult_mute) begin
                check("mult_start_expected", 32'(mult_q.size() != 0), 32'd1);
                if (mult_q.size() != 0) begin
                    e = mult_q.pop_front();
                    check("mult_A", 32'(bus.mult_A), 32'(e.a));
                    check("mult_B", 32'(bus.mult_B), 32'(e.b));
                    @(negedge CLK100MHZ);
                    check("mult_valid_one_cycle", 32'(bus.mult_valid), 32'd0);
                    check("mult_A_stable", 32'(bus.mult_A), 32'(e.a));
                    repeat (2) @(posedge CLK100MHZ);
                    #1;
                    resp_mult_res  = e.prod;
                    resp_mult_done = 1'b1;
                    @(posedge CLK100MHZ);
                    #1;
                    resp_mult_done = 1'b0;
                end
            end
        end
    end

    // BCD converter model: checks the magnitude on bcd_start and answers later.
    initial begin : bcd_responder
        bcd_exp_t e;
        forever begin
            @(negedge CLK100MHZ);
            if (bus.bcd_start) begin
                check("bcd_start_expected", 32'(bcd_q.size() != 0), 32'd1);
                if (bcd_q.size() != 0) begin
                    e = bcd_q.pop_front();
                    check("bcd_bin", 32'(bus.bcd_bin), 32'(e.mag));
                    repeat (bcd_delay) @(posedge CLK100MHZ);
                    #1;
                    resp_bcd_cod  = e.code;
                    resp_bcd_done = 1'b1;
                    @(posedge CLK100MHZ);
                    #1;
                    resp_bcd_done = 1'b0;
                end
            end
        end
    end

    // Publication monitor: compares codigo_BCD on every hecho, plus latencies.
    initial begin : monitor
        logic        prev_mult_done = 1'b0;
        logic        prev_bcd_done  = 1'b0;
        logic        prev_hecho     = 1'b0;
        logic [20:0] e;
        forever begin
            @(negedge CLK100MHZ);
            if (hecho) begin
                check("hecho_latency", 32'(prev_bcd_done), 32'd1);
                check("hecho_one_cycle", 32'(prev_hecho), 32'd0);
                check("hecho_expected", 32'(pub_q.size() != 0), 32'd1);
                if (pub_q.size() != 0) begin
                    e = pub_q.pop_front();
                    check("codigo_BCD", 32'(codigo_BCD), 32'(e));
                end
            end
            if (bus.bcd_start) begin
                check("bcd_start_latency", 32'(prev_mult_done), 32'd1);
            end
            prev_mult_done = bus.mult_done;
            prev_bcd_done  = bus.bcd_done;
            prev_hecho     = hecho;
        end
    end

    // Hard stop in case anything wedges.
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse(input logic [7:0] a, input logic [7:0] b);
        @(posedge CLK100MHZ);
        #1;
        pb_pulso = 1'b1;
        A_in     = a;
        B_in     = b;
        @(posedge CLK100MHZ);
        #1;
        pb_pulso = 1'b0;
    endtask

    task automatic expect_run(input logic [7:0] a, input logic [7:0] b, input logic [15:0] prod,
                              input logic [14:0] mag, input logic [19:0] code, input logic [20:0] pub);
        mult_q.push_back('{a: a, b: b, prod: prod});
        bcd_q.push_back('{mag: mag, code: code});
        pub_q.push_back(pub);
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK100MHZ);
            if (!ocupado && pub_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic wait_bcd_start(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK100MHZ);
            if (bus.bcd_start) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 32'(ok), 32'd1);
    endtask

    initial begin : stimulus
        // Reset state
        repeat (3) @(posedge CLK100MHZ);
        @(negedge CLK100MHZ);
        check("rst_ocupado", 32'(ocupado), 32'd0);
        check("rst_hecho", 32'(hecho), 32'd0);
        check("rst_error", 32'(error_timeout), 32'd0);
        check("rst_codigo", 32'(codigo_BCD), 32'd0);
        check("rst_mult_valid", 32'(bus.mult_valid), 32'd0);
        check("rst_bcd_start", 32'(bus.bcd_start), 32'd0);
        check("rst_mult_A", 32'(bus.mult_A), 32'd0);
        check("rst_bcd_bin", 32'(bus.bcd_bin), 32'd0);
        @(posedge CLK100MHZ);
        #1;
        reset = 1'b1;

        // 3 x -4 = -12
        expect_run(8'd3, 8'hFC, 16'hFFF4, 15'd12, 20'h00012, 21'h100012);
        pulse(8'd3, 8'hFC);
        @(negedge CLK100MHZ);
        check("start_latency", 32'(bus.mult_valid), 32'd1);
        check("busy_in_carga", 32'(ocupado), 32'd1);
        wait_idle("run_3x-4");
        check("codigo_hold_3x-4", 32'(codigo_BCD), 32'h100012);
        check("no_error_3x-4", 32'(error_timeout), 32'd0);

        // -128 x -128 = +16384 (largest magnitude)
        expect_run(8'h80, 8'h80, 16'h4000, 15'd16384, 20'h16384, 21'h016384);
        pulse(8'h80, 8'h80);
        wait_idle("run_-128x-128");

        // zero product publishes a positive sign
        expect_run(8'd0, 8'hFB, 16'h0000, 15'd0, 20'h00000, 21'h000000);
        pulse(8'd0, 8'hFB);
        wait_idle("run_0x-5");

        // 127 x -128 = -16256 (most negative)
        expect_run(8'h7F, 8'h80, 16'hC080, 15'd16256, 20'h16256, 21'h116256);
        pulse(8'h7F, 8'h80);
        wait_idle("run_127x-128");

        // Multiplier never answers: abort after exactly 1000 wait cycles
        mult_mute = 1'b1;
        pulse(8'd1, 8'd1);
        @(negedge CLK100MHZ);
        check("to_mult_valid", 32'(bus.mult_valid), 32'd1);
        for (int k = 1; k <= 1001; k++) begin
            @(negedge CLK100MHZ);
            if (k == 1000) begin
                check("to_not_yet_error", 32'(error_timeout), 32'd0);
                check("to_not_yet_idle", 32'(ocupado), 32'd1);
            end
            if (k == 1001) begin
                check("to_error_set", 32'(error_timeout), 32'd1);
                check("to_idle", 32'(ocupado), 32'd0);
                check("to_codigo_kept", 32'(codigo_BCD), 32'h116256);
            end
        end
        mult_mute = 1'b0;
        expect_run(8'd2, 8'd3, 16'h0006, 15'd6, 20'h00006, 21'h000006);
        pulse(8'd2, 8'd3);
        @(negedge CLK100MHZ);
        check("to_error_cleared", 32'(error_timeout), 32'd0);
        wait_idle("run_after_timeout");

        // Two requests during ESPERA_BCD: only the latest (7 x -2) runs next
        bcd_delay = 8;
        expect_run(8'd5, 8'd5, 16'h0019, 15'd25, 20'h00025, 21'h000025);
        pulse(8'd5, 8'd5);
        wait_bcd_start("pend_first_bcd_start");
        pulse(8'd9, 8'd9);
        expect_run(8'd7, 8'hFE, 16'hFFF2, 15'd14, 20'h00014, 21'h100014);
        pulse(8'd7, 8'hFE);
        wait_idle("run_pending_latest");
        check("codigo_pending", 32'(codigo_BCD), 32'h100014);

        // Pulse in the PUBLICA cycle overwrites a parked request
        expect_run(8'd4, 8'd4, 16'h0010, 15'd16, 20'h00016, 21'h000016);
        pulse(8'd4, 8'd4);
        wait_bcd_start("ovw_bcd_start");
        pulse(8'd1, 8'd1);
        expect_run(8'd2, 8'hFD, 16'hFFFA, 15'd6, 20'h00006, 21'h100006);
        begin : wait_publica
            bit seen = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge CLK100MHZ);
                if (hecho) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("ovw_hecho_seen", 32'(seen), 32'd1);
        end
        pb_pulso = 1'b1;
        A_in     = 8'd2;
        B_in     = 8'hFD;
        @(posedge CLK100MHZ);
        #1;
        pb_pulso = 1'b0;
        wait_idle("run_overwrite");
        check("codigo_overwrite", 32'(codigo_BCD), 32'h100006);
        bcd_delay = 2;

        // Reset in ESPERA_MULT, then a stray mult_done
        mult_mute = 1'b1;
        pulse(8'd3, 8'd3);
        repeat (3) @(negedge CLK100MHZ);
        check("mid_busy", 32'(ocupado), 32'd1);
        @(posedge CLK100MHZ);
        #1;
        reset = 1'b0;
        @(negedge CLK100MHZ);
        check("mid_rst_ocupado", 32'(ocupado), 32'd0);
        check("mid_rst_codigo", 32'(codigo_BCD), 32'd0);
        check("mid_rst_mult_A", 32'(bus.mult_A), 32'd0);
        check("mid_rst_mult_B", 32'(bus.mult_B), 32'd0);
        check("mid_rst_bcd_bin", 32'(bus.bcd_bin), 32'd0);
        @(posedge CLK100MHZ);
        #1;
        reset         = 1'b1;
        man_mult_res  = 16'h0009;
        man_mult_done = 1'b1;
        @(posedge CLK100MHZ);
        #1;
        man_mult_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK100MHZ);
            check("post_rst_no_bcd_start", 32'(bus.bcd_start), 32'd0);
            check("post_rst_no_hecho", 32'(hecho), 32'd0);
            check("post_rst_idle", 32'(ocupado), 32'd0);
        end

        // Done strobes outside their wait states are ignored
        @(posedge CLK100MHZ);
        #1;
        man_mult_done = 1'b1;
        @(posedge CLK100MHZ);
        #1;
        man_mult_done = 1'b0;
        @(negedge CLK100MHZ);
        check("stray_mult_done_idle", 32'(ocupado), 32'd0);
        check("stray_mult_done_no_start", 32'(bus.mult_valid), 32'd0);
        bcd_q.push_back('{mag: 15'd9, code: 20'h00009});
        pub_q.push_back(21'h000009);
        pulse(8'd3, 8'd3);
        @(negedge CLK100MHZ);
        check("stray_mult_valid", 32'(bus.mult_valid), 32'd1);
        @(posedge CLK100MHZ);
        #1;
        man_bcd_done = 1'b1;
        @(posedge CLK100MHZ);
        #1;
        man_bcd_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK100MHZ);
            check("stray_bcd_done_busy", 32'(ocupado), 32'd1);
            check("stray_bcd_done_no_start", 32'(bus.bcd_start), 32'd0);
            check("stray_operand_A", 32'(bus.mult_A), 32'd3);
        end
        @(posedge CLK100MHZ);
        #1;
        man_mult_done = 1'b1;
        @(posedge CLK100MHZ);
        #1;
        man_mult_done = 1'b0;
        wait_idle("run_after_stray");
        check("codigo_after_stray", 32'(codigo_BCD), 32'h000009);
        mult_mute = 1'b0;

        repeat (3) @(posedge CLK100MHZ);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/control_multiplicador.md
CONTROL_MULTIPLICADOR -- requirements
Module: control_multiplicador

Interface
REQ-001 SHALL provide parameter TIMEOUT_CICLOS, default 1000, max cycles spent in either wait state before abort.
REQ-002 SHALL provide port CLK100MHZ  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port pb_pulso  input  1  one-cycle debounced start request.
REQ-005 SHALL provide ports A_in, B_in  input  8 each  signed two's-complement operands, sampled with pb_pulso.
REQ-006 SHALL provide port mult_valid  output  1  one-cycle start pulse to the Booth multiplier.
REQ-007 SHALL provide ports mult_A, mult_B  output  8 each  registered operands, stable from mult_valid until mult_done.
REQ-008 SHALL provide ports mult_done  input  1 and mult_resultado  input  16  multiplier completion and signed product.
REQ-009 SHALL provide ports bcd_start  output  1 and bcd_bin  output  15  converter start pulse and unsigned magnitude.
REQ-010 SHALL provide ports bcd_done  input  1 and bcd_codigo  input  20  converter completion and 5-digit BCD.
REQ-011 SHALL provide port codigo_BCD  output  21  {sign, 5 BCD digits} to the display.
REQ-012 SHALL provide ports ocupado, hecho, error_timeout  output  1 each  busy level, one-cycle completion pulse, sticky abort flag.

Function
REQ-013 SHALL implement FSM states REPOSO, CARGA, ESPERA_MULT, CONVIERTE, ESPERA_BCD, PUBLICA.
REQ-014 REPOSO: on pb_pulso=1 SHALL latch A_in/B_in into mult_A/mult_B, clear error_timeout, go CARGA.
REQ-015 CARGA: SHALL assert mult_valid for exactly this one cycle, then go ESPERA_MULT.
REQ-016 ESPERA_MULT: on mult_done=1 SHALL register sign = mult_resultado[15] and 16-bit product, go CONVIERTE.
REQ-017 CONVIERTE: SHALL drive bcd_bin = magnitude of product (two's-complement negate when negative, low 15 bits) and assert bcd_start for this one cycle, then go ESPERA_BCD.
REQ-018 Magnitude range SHALL be 0..16384 (-128 x -128 = +16384; most negative -16256); 15 bits never overflow.
REQ-019 ESPERA_BCD: on bcd_done=1 SHALL go PUBLICA.
REQ-020 PUBLICA: SHALL load codigo_BCD = {sign, bcd_codigo}, assert hecho for this one cycle, go REPOSO.
REQ-021 codigo_BCD SHALL hold its value at all other times, including after an abort.
REQ-022 Zero product SHALL publish sign=0.
REQ-023 Latency from pb_pulso to mult_valid SHALL be 1 cycle; mult_done to bcd_start 1 cycle; bcd_done to codigo_BCD update and hecho 1 cycle.
REQ-024 ocupado SHALL be 1 in every state except REPOSO.
REQ-025 mult_done and bcd_done SHALL be ignored outside ESPERA_MULT and ESPERA_BCD respectively.
REQ-026 A wait-state cycle counter SHALL clear on entry to each wait state; on reaching TIMEOUT_CICLOS without the matching done, SHALL set error_timeout and go REPOSO.
REQ-027 pb_pulso while ocupado=1 SHALL store operands in a one-deep pending buffer; a later pulse overwrites it (latest wins).
REQ-028 On return to REPOSO with a pending request, SHALL start it as per REQ-014 in the next cycle and clear the buffer.
REQ-029 If pb_pulso arrives in the same cycle the FSM returns to REPOSO, the new pulse SHALL overwrite the pending buffer.

Reset
REQ-030 reset=0 SHALL asynchronously force REPOSO, clear pending buffer and counter, and drive all outputs to 0 (codigo_BCD = 21'h0).
REQ-031 reset asserted mid-operation SHALL abort without pulsing hecho; later done inputs SHALL be ignored until a new start.

Verification
REQ-032 A=3, B=-4 (8'hFC), pb_pulso; mult returns 16'hFFF4 -> bcd_bin=12, BCD 20'h00012 -> codigo_BCD={1,20'h00012}, hecho 1 cycle.
REQ-033 A=B=8'h80; product 16'h4000 -> bcd_bin=16384, codigo_BCD={0,20'h16384}.
REQ-034 Start, never assert mult_done -> after 1000 wait cycles error_timeout=1, REPOSO, codigo_BCD unchanged; next pb_pulso clears error_timeout.
REQ-035 Two pb_pulso while ESPERA_BCD (5x5 then 7x-2) -> after first hecho, second run uses 7, -2, publishes {1,20'h00014}.
REQ-036 reset=0 during ESPERA_MULT, then mult_done=1 -> outputs 0, no bcd_start, no hecho.
REQ-037 mult_done pulsed in REPOSO and bcd_done in ESPERA_MULT -> no state change.
